// File: rtl/draw_scheduler_pkg.sv
// Shared types and constants for the Mastermind board draw scheduler:
// shape encodings, per-shape sizes, screen limits and feedback peg layout.
package draw_pkg;

  typedef enum logic [1:0] {
    SHAPE_BIG    = 2'd0,
    SHAPE_MEDIUM = 2'd1,
    SHAPE_ERASE  = 2'd2,
    SHAPE_PEGS   = 2'd3
  } shape_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int COL_W = 7;
  localparam int ROW_W = 5;

  localparam logic [COL_W-1:0] BIG_W   = 7'd20;
  localparam logic [COL_W-1:0] MED_W   = 7'd10;
  localparam logic [COL_W-1:0] ERASE_W = 7'd110;
  localparam logic [COL_W-1:0] PEGS_W  = 7'd22;

  localparam logic [ROW_W-1:0] BIG_H   = 5'd20;
  localparam logic [ROW_W-1:0] MED_H   = 5'd10;
  localparam logic [ROW_W-1:0] ERASE_H = 5'd20;
  localparam logic [ROW_W-1:0] PEGS_H  = 5'd4;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [COL_W-1:0] PEG_PITCH = 7'd6;
  localparam logic [COL_W-1:0] PEG_W     = 7'd4;
  localparam logic [2:0]       COLOUR_WHITE = 3'b111;

  // Marker returned by peg_index for columns that fall in a gap.
  localparam logic [2:0] PEG_NONE = 3'd7;

  function automatic logic [COL_W-1:0] shape_width(input shape_t s);
    case (s)
      SHAPE_BIG:    return BIG_W;
      SHAPE_MEDIUM: return MED_W;
      SHAPE_ERASE:  return ERASE_W;
      default:      return PEGS_W;
    endcase
  endfunction

  function automatic logic [ROW_W-1:0] shape_height(input shape_t s);
    case (s)
      SHAPE_BIG:    return BIG_H;
      SHAPE_MEDIUM: return MED_H;
      SHAPE_ERASE:  return ERASE_H;
      default:      return PEGS_H;
    endcase
  endfunction

  // Which of the four feedback pegs a column belongs to, without dividing.
  function automatic logic [2:0] peg_index(input logic [COL_W-1:0] col);
    logic [2:0]       idx;
    logic [COL_W-1:0] base;
    idx  = PEG_NONE;
    base = '0;
    for (int k = 0; k < 4; k++) begin
      if (col >= base && col < base + PEG_W) idx = 3'(k);
      base = base + PEG_PITCH;
    end
    return idx;
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Command channel from the game FSM into the draw scheduler.
// With DRAW_SCHEDULER_FEEDBACK_SPLIT_EN the channel also carries cmd_peg_black.
interface draw_scheduler_if
  import draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                cmd_valid;
  logic                cmd_ready;
  shape_t              cmd_shape;
  logic [X_W-1:0]      cmd_x;
  logic [Y_W-1:0]      cmd_y;
  logic [COLOUR_W-1:0] cmd_colour;
  logic [2:0]          cmd_peg_count;
`ifdef DRAW_SCHEDULER_FEEDBACK_SPLIT_EN
  logic [2:0]          cmd_peg_black;

  modport master (
    output cmd_valid, cmd_shape, cmd_x, cmd_y, cmd_colour, cmd_peg_count, cmd_peg_black,
    input  cmd_ready
  );
  modport slave (
    input  cmd_valid, cmd_shape, cmd_x, cmd_y, cmd_colour, cmd_peg_count, cmd_peg_black,
    output cmd_ready
  );
`else
  modport master (
    output cmd_valid, cmd_shape, cmd_x, cmd_y, cmd_colour, cmd_peg_count,
    input  cmd_ready
  );
  modport slave (
    input  cmd_valid, cmd_shape, cmd_x, cmd_y, cmd_colour, cmd_peg_count,
    output cmd_ready
  );
`endif
endinterface

// File: rtl/draw_scheduler_shape_scan.sv
// Raster scan counter: col runs 0..width-1, then row steps, wrapping to
// (0,0) after the last pixel. start clears, advance steps one pixel.
module shape_scan
  import draw_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             advance,
  input  logic [COL_W-1:0] width,
  input  logic [ROW_W-1:0] height,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);
  logic col_end;
  logic row_end;

  assign col_end = (col == width - 1'b1);
  assign row_end = (row == height - 1'b1);
  assign last    = col_end & row_end;

  // Column/row counters in raster order.
  always_ff @(posedge clock) begin
    if (reset || start) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/draw_scheduler.sv
// Draw scheduler: accepts one rectangle command and emits one registered
// pixel write per clock until the shape is swept, then pulses done.
// Optional feature macro: DRAW_SCHEDULER_FEEDBACK_SPLIT_EN (black/white pegs).
//
// state   | meaning
// IDLE    | ready for a command; pixel (0,0) is registered on accept
// DRAW    | one pixel on the outputs per cycle
// DONE    | one-cycle completion pulse
//
// The scan counter runs one pixel ahead of the outputs, so the handshake
// cycle already registers pixel (0,0) and last_q marks the final output pixel.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  draw_scheduler_if.slave     cmd,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);
  state_t state, state_nxt;
  logic   accept, emit, ready, last_q;

  shape_t              shape_q, src_shape;
  logic [X_W-1:0]      org_x, src_x;
  logic [Y_W-1:0]      org_y, src_y;
  logic [COLOUR_W-1:0] colour_q, src_colour;
  logic [2:0]          peg_count_q, src_pc;
`ifdef DRAW_SCHEDULER_FEEDBACK_SPLIT_EN
  logic [2:0]          peg_black_q, src_black, black_lim;
`endif

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic                scan_last;

  logic [X_W:0]        x_sum;
  logic [Y_W:0]        y_sum;
  logic [2:0]          peg_k;
  logic                in_screen, peg_vis, plot_nxt;
  logic [COLOUR_W-1:0] pix_colour;

  assign cmd.cmd_ready = ready;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshake and status outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    emit      = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (cmd.cmd_valid) begin
          accept    = 1'b1;
          emit      = 1'b1;
          state_nxt = ST_DRAW;
        end
      end
      ST_DRAW: begin
        busy = 1'b1;
        if (last_q) state_nxt = ST_DONE;
        else        emit      = 1'b1;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch; the live command fields are only used in the accept cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      shape_q     <= SHAPE_BIG;
      org_x       <= '0;
      org_y       <= '0;
      colour_q    <= '0;
      peg_count_q <= '0;
`ifdef DRAW_SCHEDULER_FEEDBACK_SPLIT_EN
      peg_black_q <= '0;
`endif
    end else if (accept) begin
      shape_q     <= cmd.cmd_shape;
      org_x       <= cmd.cmd_x;
      org_y       <= cmd.cmd_y;
      colour_q    <= cmd.cmd_colour;
      peg_count_q <= cmd.cmd_peg_count;
`ifdef DRAW_SCHEDULER_FEEDBACK_SPLIT_EN
      peg_black_q <= cmd.cmd_peg_black;
`endif
    end
  end

  // Marks that the pixel now on the outputs is the last of the shape.
  always_ff @(posedge clock) begin
    if (reset) last_q <= 1'b0;
    else       last_q <= emit & scan_last;
  end

  // Pixel source: the incoming command on accept, the latched one afterwards.
  always_comb begin
    src_shape  = accept ? cmd.cmd_shape     : shape_q;
    src_x      = accept ? cmd.cmd_x         : org_x;
    src_y      = accept ? cmd.cmd_y         : org_y;
    src_colour = accept ? cmd.cmd_colour    : colour_q;
    src_pc     = accept ? cmd.cmd_peg_count : peg_count_q;
`ifdef DRAW_SCHEDULER_FEEDBACK_SPLIT_EN
    src_black  = accept ? cmd.cmd_peg_black : peg_black_q;
`endif
  end

  shape_scan u_scan (
    .clock   (clock),
    .reset   (reset),
    .start   (~emit),
    .advance (emit),
    .width   (shape_width(src_shape)),
    .height  (shape_height(src_shape)),
    .col     (col),
    .row     (row),
    .last    (scan_last)
  );

  // Coordinates one bit wider than the port so off-screen pixels are caught.
  always_comb begin
    x_sum     = {1'b0, src_x} + {{(X_W + 1 - COL_W){1'b0}}, col};
    y_sum     = {1'b0, src_y} + {{(Y_W + 1 - ROW_W){1'b0}}, row};
    in_screen = (x_sum < (X_W + 1)'(SCREEN_W)) && (y_sum < (Y_W + 1)'(SCREEN_H));
    peg_k     = peg_index(col);
    // peg_count above 4 shows nothing rather than saturating.
    peg_vis   = (peg_k != PEG_NONE) && (src_pc <= 3'd4) && (peg_k < src_pc);
    plot_nxt  = in_screen && ((src_shape != SHAPE_PEGS) || peg_vis);
`ifdef DRAW_SCHEDULER_FEEDBACK_SPLIT_EN
    black_lim  = (src_black > src_pc) ? src_pc : src_black;
    pix_colour = ((src_shape == SHAPE_PEGS) && (peg_k >= black_lim))
                 ? COLOUR_W'(COLOUR_WHITE) : src_colour;
`else
    pix_colour = src_colour;
`endif
  end

  // Registered VGA adapter outputs; plot drops whenever no pixel is emitted.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else if (emit) begin
      vga_x      <= x_sum[X_W-1:0];
      vga_y      <= y_sum[Y_W-1:0];
      vga_colour <= pix_colour;
      vga_plot   <= plot_nxt;
    end else begin
      vga_plot   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: table of directed commands,
// hand-written back-to-back and mid-draw reset sequences, and random commands
// checked against a per-pixel reference built from the drawing rules.
module tb_draw_scheduler;
  import draw_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  int errors = 0;
  int checks = 0;

  draw_scheduler_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) cmd_if ();

  draw_scheduler #(.X_W(8), .Y_W(7), .COLOUR_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd        (cmd_if),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int shape; int x; int y; int colour; int pc; int blk; int exp_plots;
  } vec_t;

  typedef struct packed {
    logic [7:0] x; logic [6:0] y; logic [2:0] col; logic plot;
  } pix_t;

  pix_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int shp_w(input int s);
    case (s) 0: return 20; 1: return 10; 2: return 110; default: return 22; endcase
  endfunction

  function automatic int shp_h(input int s);
    case (s) 0: return 20; 1: return 10; 2: return 20; default: return 4; endcase
  endfunction

  // Expected output of every sweep cycle, in raster order.
  task automatic build_model(input vec_t c, output int n_plots);
    int xs, ys, colour, blk;
    bit vis;
    pix_t p;
    exp_q.delete();
    n_plots = 0;
    for (int r = 0; r < shp_h(c.shape); r++) begin
      for (int cc = 0; cc < shp_w(c.shape); cc++) begin
        xs  = c.x + cc;
        ys  = c.y + r;
        vis = (xs < 160) && (ys < 120);
        if (c.shape == 3) vis = vis && ((cc % 6) < 4) && ((cc / 6) < c.pc) && (c.pc <= 4);
        colour = c.colour;
`ifdef DRAW_SCHEDULER_FEEDBACK_SPLIT_EN
        blk = (c.blk > c.pc) ? c.pc : c.blk;
        if (c.shape == 3 && (cc / 6) >= blk) colour = 7;
`else
        blk = 0;
`endif
        p.x = 8'(xs); p.y = 7'(ys); p.col = 3'(colour); p.plot = vis;
        exp_q.push_back(p);
        if (vis) n_plots++;
      end
    end
  endtask

  task automatic drive(input vec_t c);
    cmd_if.cmd_valid     = 1'b1;
    cmd_if.cmd_shape     = shape_t'(c.shape[1:0]);
    cmd_if.cmd_x         = 8'(c.x);
    cmd_if.cmd_y         = 7'(c.y);
    cmd_if.cmd_colour    = 3'(c.colour);
    cmd_if.cmd_peg_count = 3'(c.pc);
`ifdef DRAW_SCHEDULER_FEEDBACK_SPLIT_EN
    cmd_if.cmd_peg_black = 3'(c.blk);
`endif
  endtask

  // One command from handshake to the first cycle it could accept again.
  // present=0: valid is already up from a chained previous command.
  // use_model_cnt: compare the plot count against the reference model.
  task automatic run_cmd(input string name, input vec_t c, input bit present,
                         input bit chain, input vec_t nxt, input bit use_model_cnt);
    int n, model_plots, plots, bad, first_bad;
    pix_t e;
    if (present) begin
      @(negedge clock);
      drive(c);
    end
    check({name, " ready_at_accept"}, 32'(cmd_if.cmd_ready), 32'd1);
    @(posedge clock);
    #1;
    if (chain) drive(nxt);
    else       cmd_if.cmd_valid = 1'b0;
    build_model(c, model_plots);
    n = exp_q.size();
    plots = 0; bad = 0; first_bad = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      e = exp_q[k];
      if (vga_plot === 1'b1) plots++;
      if (vga_plot !== e.plot || vga_x !== e.x || vga_y !== e.y ||
          (e.plot && vga_colour !== e.col) || busy !== 1'b1 || done !== 1'b0 ||
          cmd_if.cmd_ready !== 1'b0) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
    end
    if (bad != 0) $display("  %s: first bad sweep cycle %0d", name, first_bad);
    check({name, " bad_sweep_cycles"}, 32'(bad), 32'd0);
    check({name, " plot_count"}, 32'(plots),
          use_model_cnt ? 32'(model_plots) : 32'(c.exp_plots));
    @(negedge clock);
    check({name, " done_cycle{done,busy,ready,plot}"},
          32'({done, busy, cmd_if.cmd_ready, vga_plot}), 32'b1000);
    @(negedge clock);
    check({name, " idle_after{ready,busy,done}"},
          32'({cmd_if.cmd_ready, busy, done}), 32'b100);
  endtask

  vec_t tbl[11];
  vec_t none;

  initial begin
    int bad, plots;
    vec_t a, b, r;

    none = '{0, 0, 0, 0, 0, 0, 0};
    //          shape  x    y  col pc blk plots
    tbl[0]  = '{0,  10,  20, 4, 0, 0, 400};
    tbl[1]  = '{3, 100,  50, 5, 2, 1,  32};
    tbl[2]  = '{3, 100,  50, 5, 0, 0,   0};
    tbl[3]  = '{3, 100,  50, 5, 6, 2,   0};
    tbl[4]  = '{2,  40, 110, 1, 0, 0, 1100};
    tbl[5]  = '{1, 155, 115, 2, 0, 0,  25};
    tbl[6]  = '{3,   0,   0, 6, 4, 7,  64};
    tbl[7]  = '{0, 150, 110, 7, 0, 0, 100};
    tbl[8]  = '{3,  20,  30, 3, 5, 0,   0};
    tbl[9]  = '{1, 250,   0, 1, 0, 0,   0};
    tbl[10] = '{3, 150,   0, 2, 3, 2,  32};

    cmd_if.cmd_valid = 1'b0;
    drive(none);
    cmd_if.cmd_valid = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_status{ready,busy,done,plot}",
          32'({cmd_if.cmd_ready, busy, done, vga_plot}), 32'b1000);
    check("reset_coords{x,y,colour}", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      run_cmd($sformatf("tbl%0d", i), tbl[i], 1'b1, 1'b0, none, 1'b0);

    // Back-to-back with valid held high across both commands.
    a = '{1, 20, 30, 2, 0, 0, 100};
    b = '{3,  5,  5, 6, 3, 1,  48};
    run_cmd("b2b_first", a, 1'b1, 1'b1, b, 1'b0);
    run_cmd("b2b_second", b, 1'b0, 1'b0, none, 1'b0);
    bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (vga_plot !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("b2b_no_duplicate", 32'(bad), 32'd0);

    // Reset after 37 plots of a MEDIUM draw.
    r = '{1, 30, 30, 5, 0, 0, 100};
    @(negedge clock);
    drive(r);
    @(posedge clock);
    #1 cmd_if.cmd_valid = 1'b0;
    plots = 0;
    repeat (37) begin
      @(negedge clock);
      if (vga_plot === 1'b1) plots++;
    end
    check("rst_mid_plots_before", 32'(plots), 32'd37);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_mid_after{plot,busy,done,ready}",
          32'({vga_plot, busy, done, cmd_if.cmd_ready}), 32'b0001);
    bad = 0;
    repeat (70) begin
      @(negedge clock);
      if (done !== 1'b0 || vga_plot !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("rst_mid_no_done", 32'(bad), 32'd0);
    run_cmd("rst_mid_next", r, 1'b1, 1'b0, none, 1'b0);

    // Random commands against the reference model.
    for (int i = 0; i < 24; i++) begin
      vec_t c;
      c.shape     = int'($urandom_range(0, 3));
      c.x         = int'($urandom_range(0, 255));
      c.y         = int'($urandom_range(0, 127));
      c.colour    = int'($urandom_range(0, 7));
      c.pc        = int'($urandom_range(0, 7));
      c.blk       = int'($urandom_range(0, 7));
      c.exp_plots = 0;
      run_cmd($sformatf("rnd%0d", i), c, 1'b1, 1'b0, none, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
